// File: rtl/clkdiv_pkg.sv
// Shared types and default constants for the multi-channel clock divider.
package clkdiv_pkg;

  // Control FSM: settle after reset/standby, run while locked, freeze in standby.
  typedef enum logic [1:0] {
    StSettle  = 2'd0,
    StLocked  = 2'd1,
    StStandby = 2'd2
  } state_e;

  localparam int unsigned DefNumCh      = 2;
  localparam int unsigned DefDivW       = 8;
  localparam int unsigned DefLockCycles = 16;
  localparam logic [15:0] DefDivInit    = {8'd50, 8'd4};

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, shadow ratio/enable, and update applied
// only at a period boundary so no truncated or stretched period is produced.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned      DIV_W   = DefDivW,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(1)
) (
  input  logic             refclk,
  input  logic             reset,
  input  logic             run,       // FSM is LOCKED this cycle
  input  logic             run_next,  // FSM will be LOCKED next cycle
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             wr_en,
  output logic             pending,
  output logic             clk_out,
  output logic             clk_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] sdiv_q;
  logic             en_q, en_d;
  logic             sen_q;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             apply;
  logic [DIV_W:0]   half_d;

  // A stalled or disabled channel has no period in flight, so it updates at once.
  assign apply = pend_q && (tick_q || !en_q || !run);

  // Next-state for ratio, enable, counter and the registered clock outputs.
  always_comb begin
    div_d  = apply ? sdiv_q : div_q;
    en_d   = apply ? sen_q : en_q;
    pend_d = pend_q;
    if (apply) pend_d = 1'b0;
    if (wr)    pend_d = 1'b1;
    // Count only while running both cycles; any boundary, stall or enable edge restarts at 0.
    if (run && run_next && en_q && !tick_q) cnt_d = cnt_q + 1'b1;
    else                                    cnt_d = '0;
    half_d = ({1'b0, div_d} + 1'b1) >> 1;
    out_d  = run_next && en_d && ({1'b0, cnt_d} < half_d);
    tick_d = run_next && en_d && (cnt_d == div_d - 1'b1);
  end

  // Channel state; outputs are registered so the divided clock is glitch-free.
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= DIV_RST;
      sdiv_q <= DIV_RST;
      en_q   <= 1'b1;
      sen_q  <= 1'b1;
      pend_q <= 1'b0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      if (wr) begin
        sdiv_q <= wr_div;
        sen_q  <= wr_en;
      end
    end
  end

  assign pending  = pend_q;
  assign clk_out  = out_q;
  assign clk_tick = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider: settle/lock/standby control, configuration
// decode, and NUM_CH phase-aligned divider channels.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned             NUM_CH      = DefNumCh,
  parameter int unsigned             DIV_W       = DefDivW,
  parameter int unsigned             LOCK_CYCLES = DefLockCycles,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT    = DefDivInit,
  localparam int unsigned            CH_W        = ch_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              reset,
  input  logic              stdby,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_tick,
  output logic              extlock
);

  localparam int unsigned     SW         = $clog2(LOCK_CYCLES + 1);
  localparam logic [SW-1:0]   SettleLast = SW'(LOCK_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              extlock_q;
  logic              cfg_err_q;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] wr;
  logic              cfg_bad;
  logic              xfer;
  logic              run, run_next;

  // Control FSM next-state; settle count tracks consecutive stdby-low cycles.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      StSettle: begin
        if (stdby) begin
          state_d  = StStandby;
          settle_d = '0;
        end else if (settle_q == SettleLast) begin
          state_d  = StLocked;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StLocked: begin
        if (stdby) state_d = StStandby;
      end
      StStandby: begin
        if (!stdby) begin
          state_d  = StSettle;
          settle_d = '0;
        end
      end
      default: begin
        state_d  = StSettle;
        settle_d = '0;
      end
    endcase
  end

  // FSM, lock flag and error pulse registers.
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q   <= StSettle;
      settle_q  <= '0;
      extlock_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      extlock_q <= (state_d == StLocked);
      cfg_err_q <= xfer && cfg_bad;
    end
  end

  assign run      = (state_q == StLocked);
  assign run_next = (state_d == StLocked);

  // Channel decode; an out-of-range select is always ready so it can be rejected.
  always_comb begin
    cfg_ready = 1'b1;
    ch_hit    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pending[i];
        ch_hit[i] = 1'b1;
      end
    end
  end

  assign xfer    = cfg_valid && cfg_ready;
  assign cfg_bad = (cfg_div == '0) || !(|ch_hit);
  assign wr      = {NUM_CH{xfer && !cfg_bad}} & ch_hit;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clkdiv_chan #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_INIT[g*DIV_W +: DIV_W])
    ) u_chan (
      .refclk   (refclk),
      .reset    (reset),
      .run      (run),
      .run_next (run_next),
      .wr       (wr[g]),
      .wr_div   (cfg_div),
      .wr_en    (cfg_en),
      .pending  (pending[g]),
      .clk_out  (clk_out[g]),
      .clk_tick (clk_tick[g])
    );
  end

  assign extlock = extlock_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: time-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_clkdiv_multi;

  localparam int unsigned NCH = 3;
  localparam int unsigned DW  = 8;
  localparam int unsigned LK  = 16;
  localparam logic [NCH*DW-1:0] DINIT = {8'd5, 8'd50, 8'd4};

  localparam int ModeSettle  = 0;
  localparam int ModeLocked  = 1;
  localparam int ModeStandby = 2;

  logic           refclk, reset, stdby, cfg_valid, cfg_ready, cfg_en, cfg_err, extlock;
  logic [1:0]     cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic [NCH-1:0] clk_out, clk_tick;

  int total = 0;
  int bad   = 0;

  clkdiv_multi #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .LOCK_CYCLES (LK),
    .DIV_INIT    (DINIT)
  ) dut (
    .refclk    (refclk),
    .reset     (reset),
    .stdby     (stdby),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .clk_tick  (clk_tick),
    .extlock   (extlock)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel's phase is (now - period_start) mod div.
  int  m_div[NCH];
  bit  m_en[NCH];
  int  m_start[NCH];
  bit  m_pend[NCH];
  int  m_sdiv[NCH];
  bit  m_sen[NCH];
  bit  m_tk[NCH];
  int  m_mode, m_quiet, cyc, mch;
  bit  m_err, mr, nerr;
  logic [NCH*DW-1:0] dinit_v;

  function automatic bit exp_tick(input int c);
    if (m_mode != ModeLocked || !m_en[c]) return 1'b0;
    return ((cyc - m_start[c]) % m_div[c]) == m_div[c] - 1;
  endfunction

  function automatic bit exp_out(input int c);
    if (m_mode != ModeLocked || !m_en[c]) return 1'b0;
    return ((cyc - m_start[c]) % m_div[c]) < (m_div[c] + 1) / 2;
  endfunction

  task automatic model_init();
    dinit_v = DINIT;
    for (int c = 0; c < NCH; c++) begin
      m_div[c]   = int'(dinit_v[c*DW +: DW]);
      m_sdiv[c]  = m_div[c];
      m_en[c]    = 1'b1;
      m_sen[c]   = 1'b1;
      m_pend[c]  = 1'b0;
      m_start[c] = 0;
    end
    m_mode  = ModeSettle;
    m_quiet = 0;
    m_err   = 1'b0;
    cyc     = 0;
  endtask

  always @(posedge refclk or posedge reset) begin : model
    if (reset) begin
      model_init();
    end else begin
      for (int c = 0; c < NCH; c++) m_tk[c] = exp_tick(c);
      mch = int'(cfg_ch);
      mr  = 1'b1;
      for (int c = 0; c < NCH; c++) if (c == mch) mr = !m_pend[c];
      nerr = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (m_pend[c] && (m_tk[c] || !m_en[c] || m_mode != ModeLocked)) begin
          m_div[c]   = m_sdiv[c];
          m_en[c]    = m_sen[c];
          m_pend[c]  = 1'b0;
          m_start[c] = cyc + 1;
        end
      end
      if (cfg_valid && mr) begin
        if (cfg_div == 0 || mch >= NCH) nerr = 1'b1;
        else begin
          for (int c = 0; c < NCH; c++) begin
            if (c == mch) begin
              m_pend[c] = 1'b1;
              m_sdiv[c] = int'(cfg_div);
              m_sen[c]  = cfg_en;
            end
          end
        end
      end
      case (m_mode)
        ModeSettle: begin
          if (stdby) begin
            m_mode  = ModeStandby;
            m_quiet = 0;
          end else begin
            m_quiet++;
            if (m_quiet == LK) begin
              m_mode = ModeLocked;
              for (int c = 0; c < NCH; c++) m_start[c] = cyc + 1;
            end
          end
        end
        ModeLocked: if (stdby) m_mode = ModeStandby;
        default: begin
          if (!stdby) begin
            m_mode  = ModeSettle;
            m_quiet = 0;
          end
        end
      endcase
      m_err = nerr;
      cyc++;
    end
  end

  logic [NCH-1:0] c_eo, c_et;
  bit             c_er;

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge refclk) begin
    for (int c = 0; c < NCH; c++) begin
      c_eo[c] = exp_out(c);
      c_et[c] = exp_tick(c);
    end
    c_er = 1'b1;
    for (int c = 0; c < NCH; c++) if (c == int'(cfg_ch)) c_er = !m_pend[c];
    chk("clk_out", 32'(clk_out), 32'(c_eo));
    chk("clk_tick", 32'(clk_tick), 32'(c_et));
    chk("extlock", 32'(extlock), 32'(m_mode == ModeLocked));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("cfg_ready", 32'(cfg_ready), 32'(c_er));
  end

  task automatic cyc_step();
    @(posedge refclk);
    #2;
  endtask

  // Hold the request stable until accepted; returns just after the accepting edge.
  task automatic cfg_write(input int ch, input int div, input bit en);
    int n;
    cfg_ch    = 2'(ch);
    cfg_div   = DW'(div);
    cfg_en    = en;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 300) begin
      cyc_step();
      n++;
    end
    if (n >= 300) chk("cfg_accept_timeout", 32'(cfg_ready), 32'd1);
    cyc_step();
    cfg_valid = 1'b0;
  endtask

  int n, k, n0, n1, n2, h0, h1, h2, f0, f1, f2, r, t0;

  initial begin
    reset = 1'b1; stdby = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0;
    repeat (3) cyc_step();
    chk("reset_extlock", 32'(extlock), 32'd0);
    chk("reset_clk_out", 32'(clk_out), 32'd0);
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b0;

    // Lock after exactly LK settle edges.
    n = 0;
    while (!extlock && n < 100) begin cyc_step(); n++; end
    chk("lock_latency", 32'(n), 32'(LK));

    // 100 cycles from lock: periods 4/50/5, duty 2/2, 25/25, 3/2.
    n0 = 0; n1 = 0; n2 = 0; h0 = 0; h1 = 0; h2 = 0; f0 = -1; f1 = -1; f2 = -1;
    for (int i = 0; i < 100; i++) begin
      if (clk_tick[0]) begin n0++; if (f0 < 0) f0 = i; end
      if (clk_tick[1]) begin n1++; if (f1 < 0) f1 = i; end
      if (clk_tick[2]) begin n2++; if (f2 < 0) f2 = i; end
      h0 += int'(clk_out[0]); h1 += int'(clk_out[1]); h2 += int'(clk_out[2]);
      cyc_step();
    end
    chk("ch0_ticks", 32'(n0), 32'd25);
    chk("ch1_ticks", 32'(n1), 32'd2);
    chk("ch2_ticks", 32'(n2), 32'd20);
    chk("ch0_high", 32'(h0), 32'd50);
    chk("ch1_high", 32'(h1), 32'd50);
    chk("ch2_high", 32'(h2), 32'd60);
    chk("ch0_first_tick", 32'(f0), 32'd3);
    chk("ch1_first_tick", 32'(f1), 32'd49);
    chk("ch2_first_tick", 32'(f2), 32'd4);

    // ch0 -> div 7 written mid-period; a second write waits for the apply.
    cyc_step();
    cfg_ch = 2'd0; cfg_div = 8'd7; cfg_en = 1'b1; cfg_valid = 1'b1;
    chk("ready_idle", 32'(cfg_ready), 32'd1);
    cyc_step();
    chk("ready_held_off", 32'(cfg_ready), 32'd0);
    n = 0;
    while (!clk_tick[0] && n < 10) begin cyc_step(); n++; end
    chk("old_period_tick", 32'(clk_tick[0]), 32'd1);
    chk("ready_at_apply", 32'(cfg_ready), 32'd0);
    n0 = 0; h0 = 0; f0 = -1;
    for (int i = 1; i <= 14; i++) begin
      cyc_step();
      if (i == 1) chk("ready_after_apply", 32'(cfg_ready), 32'd1);
      if (i == 2) cfg_valid = 1'b0;
      if (clk_tick[0]) begin n0++; if (f0 < 0) f0 = i; end
      h0 += int'(clk_out[0]);
    end
    chk("div7_ticks", 32'(n0), 32'd2);
    chk("div7_high", 32'(h0), 32'd8);
    chk("div7_first_tick", 32'(f0), 32'd7);

    // Rejected requests: zero ratio, then out-of-range channel.
    cfg_write(0, 0, 1'b1);
    chk("err_div0_pulse", 32'(cfg_err), 32'd1);
    cyc_step();
    chk("err_div0_clear", 32'(cfg_err), 32'd0);
    cfg_write(3, 5, 1'b1);
    chk("err_ch3_pulse", 32'(cfg_err), 32'd1);
    cyc_step();
    chk("err_ch3_clear", 32'(cfg_err), 32'd0);

    // Standby for 10 cycles while locked.
    stdby = 1'b1;
    cyc_step();
    chk("stdby_extlock", 32'(extlock), 32'd0);
    chk("stdby_clk_out", 32'(clk_out), 32'd0);
    chk("stdby_clk_tick", 32'(clk_tick), 32'd0);
    repeat (9) cyc_step();
    stdby = 1'b0;
    // One edge leaves standby, then LK settle edges.
    n = 0;
    while (!extlock && n < 100) begin cyc_step(); n++; end
    chk("relock_latency", 32'(n), 32'(LK + 1));
    chk("realigned", 32'(clk_out), 32'b111);

    // Disable ch1: final period completes, then it stays low; re-enable restarts.
    cfg_write(1, 50, 1'b0);
    n = 0;
    while (!clk_tick[1] && n < 60) begin cyc_step(); n++; end
    chk("ch1_final_tick", 32'(clk_tick[1]), 32'd1);
    h1 = 0;
    for (int i = 0; i < 60; i++) begin
      cyc_step();
      h1 += int'(clk_out[1]) + int'(clk_tick[1]);
    end
    chk("ch1_disabled_quiet", 32'(h1), 32'd0);
    cfg_write(1, 50, 1'b1);
    chk("ch1_reenable_wait", 32'(clk_out[1]), 32'd0);
    cyc_step();
    chk("ch1_restart", 32'(clk_out[1]), 32'd1);

    // Randomized traffic: writes (some invalid), standby bursts and idle gaps.
    for (int op = 0; op < 300; op++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        cfg_write($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 3) != 0);
      end else if (r == 7) begin
        stdby = 1'b1;
        t0 = $urandom_range(1, 6);
        repeat (t0) cyc_step();
        stdby = 1'b0;
      end else begin
        t0 = $urandom_range(1, 20);
        repeat (t0) cyc_step();
      end
    end

    // Asynchronous reset mid-operation.
    n = 0;
    while (!extlock && n < 100) begin cyc_step(); n++; end
    chk("pre_reset_locked", 32'(extlock), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_clk_out", 32'(clk_out), 32'd0);
    chk("async_rst_clk_tick", 32'(clk_tick), 32'd0);
    chk("async_rst_extlock", 32'(extlock), 32'd0);
    chk("async_rst_cfg_err", 32'(cfg_err), 32'd0);
    repeat (2) cyc_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
